// File: rtl/tx_scheduler_if.sv
// Request/handshake bundle between the transmit scheduler and its environment.
// The scheduler side uses the slave modport; the requester/serializer side uses master.
interface tx_scheduler_if;
  logic       write;
  logic       sw1;
  logic       sw2;
  logic       sw3;
  logic       sw4;
  logic       auto;
  logic       tx_done;
  logic       tx_start;
  logic [1:0] tx_sel;
  logic       busy;
  logic       pending;
  logic       err;

  modport slave (
    input  write, sw1, sw2, sw3, sw4, auto, tx_done,
    output tx_start, tx_sel, busy, pending, err
  );

  modport master (
    output write, sw1, sw2, sw3, sw4, auto, tx_done,
    input  tx_start, tx_sel, busy, pending, err
  );
endinterface

// File: rtl/tx_scheduler.sv
// Chooses which switch pattern the serializer sends next (manual strobe or auto
// round-robin), issues one start pulse, waits for done or timeout, then idles.
module tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic           sysclk,
  input logic           reset,
  tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t           state;
  logic             write_q;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [3:0] sw_vec;
  logic       any_sw;
  logic       req_edge;
  logic [1:0] man_idx;
  logic [1:0] auto_idx;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    sw_vec   = {bus.sw4, bus.sw3, bus.sw2, bus.sw1};
    any_sw   = |sw_vec;
    req_edge = bus.write & ~write_q;

    man_idx = 2'd3;
    if (sw_vec[0])      man_idx = 2'd0;
    else if (sw_vec[1]) man_idx = 2'd1;
    else if (sw_vec[2]) man_idx = 2'd2;

    // Scan the four positions after rr_ptr; i=4 wraps back onto rr_ptr itself.
    auto_idx = rr_ptr;
    found    = 1'b0;
    cand     = rr_ptr;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = rr_ptr + i[1:0];
      if (!found && sw_vec[cand]) begin
        auto_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      rr_ptr       <= 2'd3;
      cnt          <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_sel   <= 2'd0;
      bus.busy     <= 1'b0;
      bus.pending  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      write_q      <= bus.write;
      bus.tx_start <= 1'b0;

      // In IDLE a latched request is always consumed: served if a switch is on, dropped otherwise.
      if (bus.pending) begin
        if (state == IDLE) bus.pending <= 1'b0;
      end else if (req_edge) begin
        bus.pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.pending && any_sw) begin
            bus.tx_sel   <= man_idx;
            rr_ptr       <= man_idx;
            bus.tx_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end else if (!bus.pending && bus.auto && any_sw) begin
            bus.tx_sel   <= auto_idx;
            rr_ptr       <= auto_idx;
            bus.tx_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            cnt   <= '0;
            state <= GAP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.err <= 1'b1;
            cnt     <= '0;
            state   <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scenario tasks plus a randomized run checked against a transaction-level model
// of pattern selection, start latency, timeout and gap timing.
module tb_tx_scheduler;
  localparam int G = 4;
  localparam int T = 16;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  tx_scheduler_if bus ();

  tx_scheduler #(
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (5)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] v);
    {bus.sw4, bus.sw3, bus.sw2, bus.sw1} = v;
  endtask

  task automatic pulse_write();
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = 0;
    while (bus.tx_start !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic count_starts(input int ncyc, output int s);
    s = 0;
    repeat (ncyc) begin
      tick();
      if (bus.tx_start === 1'b1) s++;
    end
  endtask

  function automatic logic [1:0] prio(input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] r, input logic [3:0] s);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(r) + k) % 4;
      if (s[idx]) return 2'(idx);
    end
    return r;
  endfunction

  task automatic test_reset();
    bus.write = 0; bus.auto = 0; bus.tx_done = 0; set_sw(4'b0000);
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({bus.tx_start, bus.tx_sel, bus.busy, bus.pending, bus.err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.tx_start, bus.tx_sel, bus.busy, bus.pending, bus.err});
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b start=%b want 0 0", bus.busy, bus.tx_start);
    end
  endtask

  task automatic test_manual_basic();
    set_sw(4'b0010);
    pulse_write();
    total++;
    if (bus.pending !== 1'b1 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL edge_pending: pending=%b start=%b want 1 0", bus.pending, bus.tx_start);
    end
    tick();
    total++;
    if (bus.tx_start !== 1'b1 || bus.tx_sel !== 2'd1 || bus.busy !== 1'b1 || bus.pending !== 1'b0) begin
      bad++;
      $display("FAIL start_latency: start=%b sel=%0d busy=%b pending=%b want 1 1 1 0",
               bus.tx_start, bus.tx_sel, bus.busy, bus.pending);
    end
    tick();
    total++;
    if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL start_single: start=%b busy=%b want 0 1", bus.tx_start, bus.busy);
    end
    repeat (8) tick();
    pulse_done();
    repeat (G - 1) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL gap_busy: busy=%b err=%b want 1 0", bus.busy, bus.err);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL gap_end: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_priority_pending();
    int n, s;
    set_sw(4'b0101);
    pulse_write();
    tick();
    total++;
    if (bus.tx_start !== 1'b1 || bus.tx_sel !== 2'd0) begin
      bad++;
      $display("FAIL prio_sel: start=%b sel=%0d want 1 0", bus.tx_start, bus.tx_sel);
    end
    tick();
    pulse_write();
    total++;
    if (bus.pending !== 1'b1) begin
      bad++;
      $display("FAIL pending_in_wait: pending=%b want 1", bus.pending);
    end
    tick();
    pulse_write();
    tick();
    pulse_done();
    wait_start(20, n);
    total++;
    if (bus.tx_start !== 1'b1 || n != G + 1 || bus.tx_sel !== 2'd0 || bus.pending !== 1'b0) begin
      bad++;
      $display("FAIL pending_served: start=%b delay=%0d sel=%0d pending=%b want 1 %0d 0 0",
               bus.tx_start, n, bus.tx_sel, bus.pending, G + 1);
    end
    tick(); tick();
    pulse_done();
    count_starts(G + 8, s);
    total++;
    if (s != 0 || bus.pending !== 1'b0) begin
      bad++;
      $display("FAIL third_edge_dropped: extra starts=%0d pending=%b want 0 0", s, bus.pending);
    end
  endtask

  task automatic test_auto();
    logic [1:0] exp [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    int n, s;
    do_reset();
    set_sw(4'b1101);
    bus.auto = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start(G + 8, n);
      total++;
      if (bus.tx_start !== 1'b1 || bus.tx_sel !== exp[k]) begin
        bad++;
        $display("FAIL auto_seq[%0d]: start=%b sel=%0d want 1 %0d", k, bus.tx_start, bus.tx_sel, exp[k]);
      end
      tick(); tick();
      if (k == 4) bus.auto = 1'b0;
      tick(); tick();
      pulse_done();
    end
    count_starts(G + 10, s);
    total++;
    if (s != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL auto_stop: starts=%0d busy=%b want 0 0", s, bus.busy);
    end
  endtask

  task automatic test_manual_vs_auto();
    int n, s;
    do_reset();
    set_sw(4'b0010);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.auto  = 1'b1;
    total++;
    if (bus.tx_start !== 1'b0 || bus.pending !== 1'b1) begin
      bad++;
      $display("FAIL mva_latch: start=%b pending=%b want 0 1", bus.tx_start, bus.pending);
    end
    tick();
    total++;
    if (bus.tx_start !== 1'b1 || bus.tx_sel !== 2'd1 || bus.pending !== 1'b0) begin
      bad++;
      $display("FAIL mva_manual_first: start=%b sel=%0d pending=%b want 1 1 0",
               bus.tx_start, bus.tx_sel, bus.pending);
    end
    tick(); tick();
    pulse_done();
    wait_start(20, n);
    total++;
    if (bus.tx_start !== 1'b1 || bus.tx_sel !== 2'd1 || n != G + 1) begin
      bad++;
      $display("FAIL mva_auto_next: start=%b sel=%0d delay=%0d want 1 1 %0d",
               bus.tx_start, bus.tx_sel, n, G + 1);
    end
    bus.auto = 1'b0;
    tick();
    pulse_done();
    count_starts(G + 8, s);
    total++;
    if (s != 0) begin
      bad++;
      $display("FAIL mva_quiet: starts=%0d want 0", s);
    end
  endtask

  task automatic test_timeout();
    int s;
    do_reset();
    set_sw(4'b0010);
    pulse_write();
    tick();
    repeat (T) tick();
    total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: err=%b busy=%b want 0 1", bus.err, bus.busy);
    end
    tick();
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err: err=%b busy=%b want 1 1", bus.err, bus.busy);
    end
    repeat (G) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_gap: busy=%b err=%b want 0 1", bus.busy, bus.err);
    end
    pulse_done();
    count_starts(6, s);
    total++;
    if (bus.err !== 1'b1 || s != 0) begin
      bad++;
      $display("FAIL err_sticky: err=%b starts=%0d want 1 0", bus.err, s);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    set_sw(4'b0010);
    pulse_write();
    tick();
    tick(); tick();
    pulse_write();
    total++;
    if (bus.err !== 1'b1 || bus.pending !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_before: err=%b pending=%b busy=%b want 1 1 1", bus.err, bus.pending, bus.busy);
    end
    do_reset();
    total++;
    if ({bus.tx_start, bus.tx_sel, bus.busy, bus.pending, bus.err} !== 6'b0) begin
      bad++;
      $display("FAIL rmid_after: got %b want 000000",
               {bus.tx_start, bus.tx_sel, bus.busy, bus.pending, bus.err});
    end
    pulse_done();
    count_starts(G + 8, s);
    total++;
    if (s != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_late_done: starts=%0d busy=%b want 0 0", s, bus.busy);
    end
  endtask

  task automatic test_no_switch();
    int s;
    set_sw(4'b0000);
    pulse_write();
    total++;
    if (bus.pending !== 1'b1) begin
      bad++;
      $display("FAIL nosw_pending: pending=%b want 1", bus.pending);
    end
    tick();
    total++;
    if (bus.pending !== 1'b0 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL nosw_clear: pending=%b start=%b want 0 0", bus.pending, bus.tx_start);
    end
    count_starts(10, s);
    total++;
    if (s != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL nosw_quiet: starts=%0d busy=%b want 0 0", s, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [1:0] rr, exp;
    logic [3:0] sw;
    logic       err_m, tmo;
    int         j_done, end_tick;
    do_reset();
    rr    = 2'd3;
    err_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      sw = 4'($urandom_range(1, 15));
      set_sw(sw);
      if ($urandom_range(0, 1) == 1) begin
        exp = prio(sw);
        pulse_write();
        tick();
      end else begin
        exp = rr_next(rr, sw);
        bus.auto = 1'b1;
        tick();
        bus.auto = 1'b0;
      end
      rr = exp;
      total++;
      if (bus.tx_start !== 1'b1 || bus.tx_sel !== exp || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL rnd_start[%0d]: start=%b sel=%0d busy=%b want 1 %0d 1",
                 it, bus.tx_start, bus.tx_sel, bus.busy, exp);
      end
      j_done   = $urandom_range(1, T + 3);
      tmo      = (j_done < 2 || j_done > T + 1);
      end_tick = tmo ? T + 1 : j_done;
      for (int j = 1; j <= end_tick; j++) begin
        bus.tx_done = (j == j_done);
        if (j >= 2) set_sw(4'($urandom_range(0, 15)));
        tick();
      end
      bus.tx_done = 1'b0;
      err_m = err_m | tmo;
      total++;
      if (bus.err !== err_m || bus.busy !== 1'b1 || bus.tx_sel !== exp) begin
        bad++;
        $display("FAIL rnd_end[%0d]: err=%b busy=%b sel=%0d want %b 1 %0d",
                 it, bus.err, bus.busy, bus.tx_sel, err_m, exp);
      end
      repeat (G - 1) tick();
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL rnd_gap[%0d]: busy=%b want 1", it, bus.busy);
      end
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.tx_sel !== exp || bus.tx_start !== 1'b0) begin
        bad++;
        $display("FAIL rnd_idle[%0d]: busy=%b sel=%0d start=%b want 0 %0d 0",
                 it, bus.busy, bus.tx_sel, bus.tx_start, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_basic();
    test_priority_pending();
    test_auto();
    test_manual_vs_auto();
    test_timeout();
    test_reset_mid();
    test_no_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
